pc_update_unit: RTL and testbench

- Sequential consumer of the branch-condition unit's PCAsrc/PCBsrc selects. It owns the architectural PC register and computes next PC = (PCAsrc ? imm : 4) + (PCBsrc ? rs1 : pc).
- Sequences one instruction at a time through fetch request, fetch response, execute and commit.
- Traps on a misaligned target and counts retired instructions.
- Sits between the IFU and the execute datapath of the single-issue core.

---
 rtl/pc_update_unit.sv | 113 +++++++++++
 tb/tb_pc_update_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
// pc_update_unit
//   Owns the architectural PC of the single-issue core. Steps each instruction
//   through fetch request, fetch response, execute and commit. Computes
//   next_pc = (pc_a_src ? imm : 4) + (pc_b_src ? rs1 : pc), traps on a
//   misaligned target and counts retired instructions.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   pc_a_src        adder A select (0: constant 4, 1: imm)
//   pc_b_src        adder B select (0: pc, 1: rs1 for jalr)
//   imm, rs1        decoder immediate, rs1 read data
//   commit          current instruction finished; apply next_pc
//   ifu_req_valid   fetch request for the address on pc
//   ifu_req_ready   IFU accepts the request
//   ifu_rsp_valid   IFU returns the instruction
//   inst_valid      instruction at pc is available to execute
//   pc              architectural PC
//   next_pc         combinational target (bit 0 cleared for jalr)
//   misalign        sticky trap flag
//   trap_pc         offending target, latched on trap
//   instret         retired-instruction counter
//
// state | meaning
// IDLE  | one cycle after reset, no outputs
// REQ   | fetch request for pc held until accepted
// WAIT  | request accepted, waiting for the IFU response
// EXEC  | instruction available, waiting for commit
// TRAP  | misaligned target seen, halted until reset
module pc_update_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_a_src,
  input  logic            pc_b_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            commit,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  input  logic            ifu_rsp_valid,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign,
  output logic [XLEN-1:0] trap_pc,
  output logic [63:0]     instret
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    TRAP = 3'd4
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_b;
  logic [XLEN-1:0] sum;
  logic            target_misaligned;
  logic            do_commit;

  assign add_a   = pc_a_src ? imm : XLEN'(4);
  assign add_b   = pc_b_src ? rs1 : pc;
  assign sum     = add_a + add_b;
  // jalr target has bit 0 forced low before the alignment test
  assign next_pc = pc_b_src ? {sum[XLEN-1:1], 1'b0} : sum;

  assign target_misaligned = |next_pc[1:0];
  assign do_commit         = (state == EXEC) && commit;

  assign ifu_req_valid = (state == REQ);
  assign inst_valid    = (state == EXEC);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ:  if (ifu_req_ready) state_next = WAIT;
      // a response coinciding with acceptance arrives while still in REQ and is dropped
      WAIT: if (ifu_rsp_valid) state_next = EXEC;
      EXEC: if (commit) state_next = target_misaligned ? TRAP : REQ;
      TRAP: state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      misalign <= 1'b0;
      trap_pc  <= '0;
      instret  <= '0;
    end else begin
      state <= state_next;
      if (do_commit) begin
        if (target_misaligned) begin
          misalign <= 1'b1;
          trap_pc  <= next_pc;
        end else begin
          pc      <= next_pc;
          instret <= instret + 64'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_update_unit.sv
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_a_src;
  logic        pc_b_src;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        commit;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        misalign;
  logic [31:0] trap_pc;
  logic [63:0] instret;

  pc_update_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_a_src      (pc_a_src),
    .pc_b_src      (pc_b_src),
    .imm           (imm),
    .rs1           (rs1),
    .commit        (commit),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_rsp_valid (ifu_rsp_valid),
    .inst_valid    (inst_valid),
    .pc            (pc),
    .next_pc       (next_pc),
    .misalign      (misalign),
    .trap_pc       (trap_pc),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        a_src;
    logic        b_src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp_next;
    logic        exp_trap;
    logic [63:0] exp_instret;
    logic        stress;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  vec_t        vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (ifu_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_timeout", {63'd0, ifu_req_valid}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [63:0] prev_instret;
    prev_instret = instret;
    wait_req();
    check("req_pc", pc, exp_pc);
    if (v.stress) begin
      // backpressure with a stray response that must not be taken
      ifu_rsp_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        check("bp_req_held", {63'd0, ifu_req_valid}, 64'd1);
        check("bp_pc_stable", pc, exp_pc);
        check("bp_no_exec", {63'd0, inst_valid}, 64'd0);
      end
      // response coincident with acceptance is not sampled
      ifu_req_ready = 1'b1;
      tick();
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      commit = 1'b1;
      tick();
      commit = 1'b0;
      check("wait_no_exec", {63'd0, inst_valid}, 64'd0);
      check("wait_req_low", {63'd0, ifu_req_valid}, 64'd0);
      check("wait_commit_ignored", instret, prev_instret);
      check("wait_pc", pc, exp_pc);
    end else begin
      ifu_req_ready = 1'b1;
      tick();
      ifu_req_ready = 1'b0;
      check("wait_req_low", {63'd0, ifu_req_valid}, 64'd0);
    end
    ifu_rsp_valid = 1'b1;
    tick();
    ifu_rsp_valid = 1'b0;
    check("exec_inst_valid", {63'd0, inst_valid}, 64'd1);
    pc_a_src = v.a_src;
    pc_b_src = v.b_src;
    imm      = v.imm;
    rs1      = v.rs1;
    commit   = 1'b1;
    #1;
    check("next_pc", next_pc, v.exp_next);
    tick();
    commit   = 1'b0;
    pc_a_src = 1'b0;
    pc_b_src = 1'b0;
    imm      = '0;
    rs1      = '0;
    if (!v.exp_trap) exp_pc = v.exp_next;
    check("pc_after", pc, exp_pc);
    check("instret", instret, v.exp_instret);
    check("misalign", {63'd0, misalign}, {63'd0, v.exp_trap});
    check("post_inst_valid", {63'd0, inst_valid}, 64'd0);
  endtask

  task automatic check_reset_state();
    check("rst_pc", pc, 64'h8000_0000);
    check("rst_misalign", {63'd0, misalign}, 64'd0);
    check("rst_trap_pc", trap_pc, 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_req_valid", {63'd0, ifu_req_valid}, 64'd0);
    check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
  endtask

  initial begin
    //         a  b  imm           rs1           exp_next      trap instret stress
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h8000_0004, 1'b0, 64'd1,  1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h8000_0008, 1'b0, 64'd2,  1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h8000_000C, 1'b0, 64'd3,  1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h8000_0010, 1'b0, 64'd4,  1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,       32'h8000_0000, 1'b0, 64'd5,  1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'h8000_0010, 1'b0, 64'd6,  1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h100,      32'h0,        32'h8000_0110, 1'b0, 64'd7,  1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h2,        32'h8000_0203, 32'h8000_0204, 1'b0, 64'd8, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h4,        32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0, 64'd9, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0000, 1'b0, 64'd10, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0,        32'h1234_5679, 32'h1234_567C, 1'b0, 64'd11, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'h2,        32'h8000_1001, 32'h8000_1002, 1'b1, 64'd11, 1'b0};

    rst = 1'b1; pc_a_src = 1'b0; pc_b_src = 1'b0; imm = '0; rs1 = '0;
    commit = 1'b0; ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
    tick();
    tick();
    check_reset_state();
    rst = 1'b0;
    #1;
    check("idle_req_low", {63'd0, ifu_req_valid}, 64'd0);
    tick();
    check("first_req", {63'd0, ifu_req_valid}, 64'd1);
    exp_pc = 32'h8000_0000;

    foreach (vecs[i]) run_vec(vecs[i]);

    check("trap_pc", trap_pc, 64'h8000_1002);
    commit = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("trap_req_low", {63'd0, ifu_req_valid}, 64'd0);
      check("trap_inst_low", {63'd0, inst_valid}, 64'd0);
      check("trap_pc_hold", pc, exp_pc);
      check("trap_instret_hold", instret, 64'd11);
      check("trap_sticky", {63'd0, misalign}, 64'd1);
    end
    commit = 1'b0; ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b0;

    // reset from TRAP
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state();
    tick();
    check("resume_req", {63'd0, ifu_req_valid}, 64'd1);
    exp_pc = 32'h8000_0000;
    run_vec('{1'b0, 1'b0, 32'h0, 32'h0, 32'h8000_0004, 1'b0, 64'd1, 1'b0});

    // reset from WAIT
    wait_req();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    check("pre_rst_wait", {63'd0, ifu_req_valid}, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state();
    exp_pc = 32'h8000_0000;
    run_vec('{1'b1, 1'b0, 32'h8, 32'h0, 32'h8000_0008, 1'b0, 64'd1, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
